pc_sequencer: RTL

- Fetch-stage controller that owns the program counter.
- Sequences straight-line fetch, load-use stalls, taken-branch redirects, and halt/drain/resume.
- Sits between the hazard unit and the MEM-stage branch resolution on one side, and instruction memory plus the IF/ID register on the other.
- PC is a word address: sequential fetch increments by 1.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/sat_counter.sv | 20 ++
 rtl/pc_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and the fetch-controller state type.
// Contents:
//   ADDR_W_DEF   - default PC / target width, shared with the PC/IMEM path
//   RESET_PC_DEF - default PC loaded on reset
//   state_t      - fetch sequencer states BOOT, RUN, DRAIN, HALT
package cpu_pkg;
    localparam int unsigned ADDR_W_DEF   = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'd0;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset, clears count
//   inc     in  count this cycle
//   count   out registered saturating count
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller owning the program counter.
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   stall                    load-use stall: hold pc, no new fetch
//   branch_taken/_target     MEM-stage redirect to a word address
//   halt_req                 MEM-stage halt pulse: drain then halt
//   resume/resume_pc         restart from HALT at resume_pc
//   pc, fetch_valid          registered fetch address and its valid
//   flush                    combinational wrong-path kill on a redirect
//   halted                   registered quiesced indication
//   redirect_count           saturating count of accepted redirects
//   stall_count              saturating count of honoured stall cycles
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC     = RESET_PC_DEF[ADDR_W-1:0],
    parameter int unsigned        DRAIN_CYCLES = 3,
    parameter int unsigned        CNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    input  logic              resume,
    input  logic [ADDR_W-1:0] resume_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  redirect_count,
    output logic [CNT_W-1:0]  stall_count
);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic              fetch_valid_n, halted_n, stall_hold;
    logic [3:0]        drain_cnt, drain_n;

    // A redirect outranks halt and stall, so a stall only counts when nothing older wins.
    assign flush      = state == RUN && branch_taken;
    assign stall_hold = state == RUN && !branch_taken && !halt_req && stall;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        fetch_valid_n = 1'b0;
        halted_n      = halted;
        drain_n       = drain_cnt;
        case (state)
            BOOT: begin
                state_n       = RUN;
                pc_n          = RESET_PC;
                fetch_valid_n = 1'b1;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_n          = branch_target;
                    fetch_valid_n = 1'b1;
                end else if (halt_req) begin
                    state_n = DRAIN;
                    drain_n = DRAIN_INIT;
                end else if (!stall) begin
                    pc_n          = pc + 1'b1;
                    fetch_valid_n = 1'b1;
                end
            end
            DRAIN: begin
                drain_n = drain_cnt - 4'd1;
                if (drain_cnt == 4'd1) begin
                    state_n  = HALT;
                    halted_n = 1'b1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_n       = RUN;
                    pc_n          = resume_pc;
                    fetch_valid_n = 1'b1;
                    halted_n      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            drain_cnt   <= 4'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fetch_valid <= fetch_valid_n;
            halted      <= halted_n;
            drain_cnt   <= drain_n;
        end

    sat_counter #(.W(CNT_W)) u_redirect_count (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush),
        .count   (redirect_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_count (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_hold),
        .count   (stall_count)
    );
endmodule
